// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   - State encoding for the sequencer FSM (IDLE / RUN).
//   - cmp_step(): one LSB-first comparison step, p' = (ai & ~bi) | (~(ai ^ bi) & p).
//     The running flag p means "the bits seen so far of a exceed those of b".
package serial_cmp_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StRun  = ST_RUN
  } state_e;

  // A higher bit that differs overrides everything below it; equal bits pass p through.
  function automatic logic cmp_step(input logic p, input logic ai, input logic bi);
    return (ai & ~bi) | (~(ai ^ bi) & p);
  endfunction

endpackage

// File: rtl/cmp_cell_lsb.sv
// Single LSB-first comparison cell, purely combinational. The sequencer time-multiplexes
// one instance of this cell across all operand bits.
// Ports:
//   p      in  1  running "a > b so far" flag from the previous bit
//   ai     in  1  current bit of operand A
//   bi     in  1  current bit of operand B
//   first  in  1  1 = bit 0: ignore p and apply the init law (ai & ~bi)
//   p_next out 1  updated flag
module cmp_cell_lsb
  import serial_cmp_pkg::*;
(
  input  logic p,
  input  logic ai,
  input  logic bi,
  input  logic first,
  output logic p_next
);

  always_comb begin
    p_next = first ? (ai & ~bi) : cmp_step(p, ai, bi);
  end

endmodule

// File: rtl/serial_cmp_sequencer.sv
// Bit-serial unsigned magnitude comparator controller: z = (a > b).
// One cmp_cell_lsb is reused over N clock cycles, LSB first. The start edge evaluates bit 0
// from the live inputs while latching them; RUN evaluates bits 1..N-1 from the latched copies.
// Optional build macro: SERIAL_CMP_ABORT_EN adds an abort input that cancels a RUN without a
// done pulse and without touching z.
// Ports:
//   clk     in  1   rising-edge clock
//   rst     in  1   synchronous active-high reset
//   start   in  1   request, only honoured while busy is low
//   a, b    in  N   operands, captured with an accepted start
//   abort   in  1   (SERIAL_CMP_ABORT_EN only) cancel the running comparison
//   busy    out 1   comparison in progress
//   done    out 1   one-cycle pulse, z valid
//   z       out 1   result, held until the next done (cleared by rst)
//   bit_idx out IW  bit being processed, 0 when idle
module serial_cmp_sequencer
  import serial_cmp_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
`ifdef SERIAL_CMP_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          z,
  output logic [IW-1:0] bit_idx
);

  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          p_q;
  logic          busy_q;
  logic          done_q;
  logic          z_q;
  logic [IW-1:0] idx_q;

  logic cell_first;
  logic cell_ai;
  logic cell_bi;
  logic p_next;
  logic abort_w;

`ifdef SERIAL_CMP_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // In IDLE the cell looks at bit 0 of the live inputs so the start edge does useful work.
  always_comb begin
    cell_first = (state_q == StIdle);
    cell_ai    = cell_first ? a[0] : a_q[idx_q];
    cell_bi    = cell_first ? b[0] : b_q[idx_q];
  end

  cmp_cell_lsb u_cell (
    .p      (p_q),
    .ai     (cell_ai),
    .bi     (cell_bi),
    .first  (cell_first),
    .p_next (p_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            p_q     <= p_next;
            idx_q   <= IW'(1);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (abort_w) begin
            // Cancelled: drop back to IDLE, keep the previous result.
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= StIdle;
          end else if (idx_q == LastIdx) begin
            z_q     <= p_next;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= StIdle;
          end else begin
            p_q   <= p_next;
            idx_q <= idx_q + IW'(1);
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign z       = z_q;
  assign bit_idx = idx_q;

endmodule
